// File: rtl/spi_ctrl_pkg.sv
// Shared encodings for the SPI bridge bus arbiter: FSM states, transaction
// op codes and the word returned when a read is aborted.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DONE    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing the SPI bridge word bus between the controller
// core (requester 0) and the debug/command path (requester 1).
//  state   | meaning
//  IDLE    | sample requests, grant round-robin, latch op and write word
//  ISSUE   | one-cycle read/write strobe to the bridge
//  WAIT    | wait for the matching response or the timeout
//  DONE    | one-cycle ack (and err) to the winner with read word
//  HOLDOFF | settle cycle for requester deassert and response tail
module spi_bus_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_read,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_write_data0,
  input  logic [31:0] req_write_data1,
  output logic [31:0] req_read_data,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_err,
  output logic        spi_read,
  output logic        spi_write,
  output logic [31:0] spi_write_data,
  input  logic [31:0] spi_read_data,
  input  logic        spi_read_response,
  input  logic        spi_write_response,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_t         state;
  op_t            op;
  logic           winner;
  logic           last_grant;
  logic [CW-1:0]  count;
  logic [1:0]     pending;
  logic           grant_id;
  logic           match_resp;

  assign pending    = req_read | req_write;
  assign match_resp = (op == OP_WRITE) ? spi_write_response : spi_read_response;

  always_comb begin
    grant_id = pending[0] ? 1'b0 : 1'b1;
    if (&pending) grant_id = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op             <= OP_READ;
      winner         <= 1'b0;
      last_grant     <= 1'b1;
      count          <= '0;
      req_read_data  <= '0;
      req_ack        <= '0;
      req_err        <= '0;
      spi_read       <= 1'b0;
      spi_write      <= 1'b0;
      spi_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      spi_read      <= 1'b0;
      spi_write     <= 1'b0;
      req_ack       <= '0;
      req_err       <= '0;
      req_read_data <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            winner         <= grant_id;
            last_grant     <= grant_id;
            // a requester holding both read and write gets its write first
            op             <= req_write[grant_id] ? OP_WRITE : OP_READ;
            spi_write      <= req_write[grant_id];
            spi_read       <= ~req_write[grant_id];
            spi_write_data <= grant_id ? req_write_data1 : req_write_data0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (match_resp) begin
            req_ack[winner] <= 1'b1;
            req_read_data   <= (op == OP_READ) ? spi_read_data : 32'h0;
            state           <= DONE;
          end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
            req_ack[winner] <= 1'b1;
            req_err[winner] <= 1'b1;
            req_read_data   <= (op == OP_READ) ? ERR_DATA : 32'h0;
            state           <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: state <= HOLDOFF;
        HOLDOFF: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: timestamp-based transaction model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_spi_bus_arbiter;

  localparam int unsigned TO   = 16;
  localparam logic [31:0] ERRW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_read, req_write;
  logic [31:0] d0, d1;
  logic [31:0] req_read_data;
  logic [1:0]  req_ack, req_err;
  logic        spi_read, spi_write;
  logic [31:0] spi_write_data;
  logic [31:0] spi_read_data;
  logic        spi_read_response, spi_write_response;
  logic        busy;

  spi_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERRW)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_write_data0(d0), .req_write_data1(d1),
    .req_read_data(req_read_data), .req_ack(req_ack), .req_err(req_err),
    .spi_read(spi_read), .spi_write(spi_write), .spi_write_data(spi_write_data),
    .spi_read_data(spi_read_data),
    .spi_read_response(spi_read_response), .spi_write_response(spi_write_response),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: tracks cycle stamps of issue, ack and next idle slot.
  bit          m_active = 0, m_w = 0, m_wr = 0, m_err = 0, m_last = 1;
  int          m_issue = -100, m_wait = 0, m_ack = -100, m_free = 0;
  logic [31:0] m_data = 0, m_wdata = 0;
  logic [1:0]  m_pend;
  bit          m_g;

  task automatic model_end(bit e, logic [31:0] d);
    m_ack    = cyc + 1;
    m_err    = e;
    m_data   = d;
    m_free   = cyc + 3;
    m_active = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_issue = -100; m_ack = -100; m_free = cyc + 1; m_last = 1;
    end else if (m_active) begin
      if (cyc >= m_wait) begin
        if (m_wr ? spi_write_response : spi_read_response)
          model_end(0, m_wr ? 32'h0 : spi_read_data);
        else if (cyc == m_wait + int'(TO) - 1)
          model_end(1, m_wr ? 32'h0 : ERRW);
      end
    end else if (cyc >= m_free) begin
      m_pend = req_read | req_write;
      if (m_pend != 2'b00) begin
        m_g      = (m_pend == 2'b11) ? !m_last : m_pend[1];
        m_last   = m_g;
        m_w      = m_g;
        m_wr     = req_write[m_g];
        m_wdata  = m_g ? d1 : d0;
        m_issue  = cyc + 1;
        m_wait   = cyc + 2;
        m_free   = 1 << 30;
        m_active = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic       e_busy, e_hit;
      logic [1:0] e_bit;
      e_busy = (cyc >= m_issue) && (cyc < m_free);
      e_hit  = (cyc == m_ack);
      e_bit  = m_w ? 2'b10 : 2'b01;
      check("busy", busy, e_busy);
      check("spi_write", spi_write, (cyc == m_issue) && m_wr);
      check("spi_read", spi_read, (cyc == m_issue) && !m_wr);
      check("req_ack", req_ack, e_hit ? e_bit : 2'b00);
      check("req_err", req_err, (e_hit && m_err) ? e_bit : 2'b00);
      check("req_read_data", req_read_data, e_hit ? m_data : 32'h0);
      if (e_busy) check("spi_write_data", spi_write_data, m_wdata);
    end
  end

  // Stimulus state: bridge behaviour and observation logs.
  bit          br_random = 0, br_none = 0, br_op_wr = 0, auto_drop = 1;
  int          br_lat = 1, br_hold = 1, br_hold_cur = 1, br_start = -1000;
  logic [31:0] br_word = 0;
  logic [1:0]  ack_log[$];
  bit          strobe_log[$];
  int          ack_cyc = 0, strobe_cyc = 0;
  logic [31:0] ack_data = 0, wdata_at_strobe = 0;
  logic [1:0]  ack_err = 0;

  task automatic step();
    bit in_win, noise;
    @(negedge clk);
    if (req_ack != 2'b00) begin
      ack_log.push_back(req_ack);
      ack_cyc  = cyc;
      ack_data = req_read_data;
      ack_err  = req_err;
      if (auto_drop)
        for (int i = 0; i < 2; i++)
          if (req_ack[i]) begin req_read[i] = 1'b0; req_write[i] = 1'b0; end
    end
    if (spi_write || spi_read) begin
      strobe_log.push_back(spi_write);
      strobe_cyc      = cyc;
      wdata_at_strobe = spi_write_data;
      if (br_random) begin
        br_none = ($urandom_range(0, 9) == 0);
        br_lat  = $urandom_range(1, 12);
        br_hold = $urandom_range(1, 3);
        br_word = $urandom;
      end
      br_op_wr    = spi_write;
      br_start    = br_none ? -1000 : cyc + br_lat;
      br_hold_cur = br_hold;
    end
    in_win = (cyc >= br_start) && (cyc < br_start + br_hold_cur);
    noise  = ($urandom_range(0, 4) == 0);
    spi_write_response = br_op_wr ? in_win : noise;
    spi_read_response  = br_op_wr ? noise : in_win;
    spi_read_data      = in_win ? br_word : $urandom;
  endtask

  task automatic wait_acks(int n, int budget, string name);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin step(); k++; end
    check(name, ack_log.size() >= n, 1'b1);
  endtask

  task automatic wait_strobe(int budget, string name);
    int k = 0;
    while (strobe_log.size() < 1 && k < budget) begin step(); k++; end
    check(name, strobe_log.size() >= 1, 1'b1);
  endtask

  int c0, s;

  initial begin
    reset = 1; req_read = 0; req_write = 0; d0 = 0; d1 = 0;
    spi_read_data = 0; spi_read_response = 0; spi_write_response = 0;
    repeat (3) step();
    chk_on = 1;
    reset = 0;
    step();
    check("rst_busy", busy, 0);
    check("rst_ack", req_ack, 0);
    check("rst_strobe", {spi_read, spi_write}, 0);
    check("rst_wdata", spi_write_data, 0);

    // write from requester 0, response 10 cycles after strobe held 2 cycles
    br_lat = 10; br_hold = 2; br_word = 0;
    ack_log.delete(); strobe_log.delete();
    d0 = 32'hA5A5_0001; req_write = 2'b01; c0 = cyc;
    wait_strobe(10, "t1_strobe_seen");
    s = strobe_cyc;
    check("t1_strobe_lat", 32'(s - c0), 1);
    check("t1_is_write", strobe_log[0], 1);
    check("t1_wdata", wdata_at_strobe, 32'hA5A5_0001);
    step();
    check("t1_pulse_width", spi_write, 0);
    wait_acks(1, 40, "t1_ack_seen");
    check("t1_ack_cycle", 32'(ack_cyc - s), 11);
    check("t1_ack_id", ack_log[0], 2'b01);
    while (cyc < s + 12) step();
    check("t1_busy_holdoff", busy, 1);
    step();
    check("t1_busy_idle", busy, 0);
    repeat (5) step();
    check("t1_ack_once", ack_log.size(), 1);

    // read from requester 1
    br_lat = 4; br_hold = 1; br_word = 32'h1234_5678;
    ack_log.delete(); strobe_log.delete();
    req_read = 2'b10;
    wait_acks(1, 40, "t2_ack_seen");
    check("t2_ack_id", ack_log[0], 2'b10);
    check("t2_rdata", ack_data, 32'h1234_5678);
    check("t2_err", ack_err, 0);
    repeat (3) step();

    // both reading continuously: strict alternation starting with 0
    br_lat = 2; br_word = 32'h0000_0033;
    ack_log.delete(); strobe_log.delete();
    auto_drop = 0; req_read = 2'b11;
    wait_acks(6, 200, "t3_acks_seen");
    req_read = 2'b00; auto_drop = 1;
    repeat (6) step();
    for (int i = 0; i < 6; i++) check("t3_order", ack_log[i], (i % 2) ? 2'b10 : 2'b01);
    check("t3_strobes", strobe_log.size(), 6);

    // no bridge response: timeout
    br_none = 1;
    ack_log.delete(); strobe_log.delete();
    req_read = 2'b01;
    wait_strobe(10, "t4_strobe_seen");
    s = strobe_cyc;
    wait_acks(1, 40, "t4_ack_seen");
    check("t4_ack_cycle", 32'(ack_cyc - s), 17);
    check("t4_err", ack_err, 2'b01);
    check("t4_rdata", ack_data, 32'hFFFF_FFFF);
    br_none = 0; br_lat = 3;
    repeat (3) step();
    ack_log.delete(); strobe_log.delete();
    d0 = 32'h0BAD_CAFE; req_write = 2'b01;
    wait_acks(1, 40, "t4_next_seen");
    check("t4_next_err", ack_err, 0);
    check("t4_next_wdata", wdata_at_strobe, 32'h0BAD_CAFE);
    repeat (3) step();

    // read and write both held by requester 0
    br_lat = 2; br_word = 32'hCAFE_0005;
    ack_log.delete(); strobe_log.delete();
    auto_drop = 0; d0 = 32'h5555_AAAA; req_read = 2'b01; req_write = 2'b01;
    wait_acks(1, 40, "t5_first_ack");
    req_write = 2'b00;
    wait_acks(2, 40, "t5_second_ack");
    req_read = 2'b00; auto_drop = 1;
    repeat (4) step();
    check("t5_first_write", strobe_log[0], 1);
    check("t5_then_read", strobe_log[1], 0);
    check("t5_rdata", ack_data, 32'hCAFE_0005);
    check("t5_count", strobe_log.size(), 2);

    // reset during WAIT with late bridge response
    br_lat = 4; br_hold = 2; br_word = 32'h7777_0006;
    ack_log.delete(); strobe_log.delete();
    req_read = 2'b01;
    wait_strobe(10, "t6_strobe_seen");
    step(); step();
    reset = 1; req_read = 2'b00;
    step();
    reset = 0;
    repeat (8) step();
    check("t6_no_ack", ack_log.size(), 0);
    check("t6_busy", busy, 0);
    req_read = 2'b11;
    wait_acks(1, 40, "t6_post_ack");
    check("t6_priority0", ack_log[0], 2'b01);
    wait_acks(2, 40, "t6_post_ack2");
    req_read = 2'b00;
    repeat (4) step();

    // random traffic
    br_random = 1; auto_drop = 1;
    for (int n = 0; n < 4000; n++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1; req_read = 2'b00; req_write = 2'b00;
      end else begin
        reset = 0;
        for (int i = 0; i < 2; i++) begin
          if (!req_read[i] && !req_write[i] && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
              0: req_read[i] = 1'b1;
              1: req_write[i] = 1'b1;
              default: begin req_read[i] = 1'b1; req_write[i] = 1'b1; end
            endcase
            if (i == 0) d0 = $urandom; else d1 = $urandom;
          end
        end
      end
    end
    reset = 0; req_read = 2'b00; req_write = 2'b00;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, limit %0d cycles", 60000);
    $fatal(1, "watchdog");
  end

endmodule
